// File: rtl/vc_rd_bank_arb.sv
// Per-bank read-command arbiter: round-robin merge of the W/E/S/N crossbar lanes into a small output FIFO.
// Optional per-source grant counters are built when VC_RD_ARB_PERF_CNT_EN is defined.
package vc_rd_bank_arb_pkg;
  typedef struct packed {
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_id;
  } input_req_pld_t;
endpackage

module vc_rd_bank_arb
  import vc_rd_bank_arb_pkg::*;
#(
  parameter int BANK_ID = 0,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_vld,
  input  input_req_pld_t [3:0] in_pld,
  output logic [3:0]           in_rdy,
  output logic                 out_vld,
  output input_req_pld_t       out_pld,
  output logic [1:0]           out_src,
  input  logic                 out_rdy,
  output logic                 bank_err
`ifdef VC_RD_ARB_PERF_CNT_EN
  ,
  output logic [3:0][CNT_W-1:0] grant_cnt
`endif
);

  // Handshake: a source transfers when in_vld[i] && in_rdy[i]; the bank takes a command when out_vld && out_rdy.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  typedef struct packed {
    input_req_pld_t pld;
    logic [1:0]     src;
  } fifo_ent_t;

  fifo_ent_t           mem_q [DEPTH];
  fifo_ent_t           mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                bank_err_q, bank_err_d;

  logic       can_push;
  logic       grant_vld;
  logic [1:0] grant_src;
  logic [1:0] idx;
  logic       push;
  logic       pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full means no grant, even if the head is popped this cycle.
  always_comb begin
    can_push  = (count_q < CNT_BITS'(DEPTH));
    grant_vld = 1'b0;
    grant_src = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_vld && in_vld[idx]) begin
        grant_vld = 1'b1;
        grant_src = idx;
      end
    end
    push   = rst_n && can_push && grant_vld;
    in_rdy = push ? (4'b0001 << grant_src) : 4'b0000;
    pop    = out_vld && out_rdy;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    bank_err_d = bank_err_q;
    count_d    = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
    if (push) begin
      mem_d[wr_ptr_q].pld = in_pld[grant_src];
      mem_d[wr_ptr_q].src = grant_src;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
      rr_ptr_d            = grant_src + 2'd1;
      if (in_pld[grant_src].cmd_addr[63:62] != 2'(BANK_ID)) begin
        bank_err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_ptr_q   <= 2'd0;
      bank_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      bank_err_q <= bank_err_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_vld  = (count_q != '0);
  assign out_pld  = mem_q[rd_ptr_q].pld;
  assign out_src  = mem_q[rd_ptr_q].src;
  assign bank_err = bank_err_q;

`ifdef VC_RD_ARB_PERF_CNT_EN
  logic [3:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (push && (grant_cnt_q[grant_src] != '1)) begin
      grant_cnt_d[grant_src] = grant_cnt_q[grant_src] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  // Counter width has no effect when the counters are not built.
  localparam int CNT_W_UNUSED = CNT_W;
`endif

endmodule

// File: tb/tb_vc_rd_bank_arb.sv
// Bench for vc_rd_bank_arb: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_vc_rd_bank_arb;
  import vc_rd_bank_arb_pkg::*;

  localparam int BANK_ID = 2;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           in_vld;
  input_req_pld_t [3:0] in_pld;
  logic [3:0]           in_rdy;
  logic                 out_vld;
  input_req_pld_t       out_pld;
  logic [1:0]           out_src;
  logic                 out_rdy;
  logic                 bank_err;
`ifdef VC_RD_ARB_PERF_CNT_EN
  logic [3:0][CNT_W-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  vc_rd_bank_arb #(.BANK_ID(BANK_ID), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_pld  (in_pld),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_pld (out_pld),
    .out_src (out_src),
    .out_rdy (out_rdy),
    .bank_err(bank_err)
`ifdef VC_RD_ARB_PERF_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  typedef struct packed {
    input_req_pld_t pld;
    logic [1:0]     src;
  } ent_t;

  // Reference model: accepted commands in grant order, rotating priority, sticky error, saturating counts.
  ent_t m_q[$];
  int   m_rr = 0;
  bit   m_err = 1'b0;
  int   m_cnt[4] = '{0, 0, 0, 0};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic input_req_pld_t mk_pld(input bit bad);
    input_req_pld_t p;
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    a[63:62] = bad ? 2'b01 : 2'(BANK_ID);
    p.cmd_addr = a;
    p.cmd_id   = 8'($urandom());
    return p;
  endfunction

  task automatic drive(input logic [3:0] v, input bit ordy, input bit bad);
    in_vld  = v;
    out_rdy = ordy;
    for (int i = 0; i < 4; i++) in_pld[i] = mk_pld(bad);
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    int g;
    int s;
    ent_t e;
    logic [3:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if (rst_n && (m_q.size() < DEPTH)) begin
      for (int k = 0; k < 4; k++) begin
        s = (m_rr + k) % 4;
        if (g < 0 && in_vld[s]) g = s;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("in_rdy", 128'(in_rdy), 128'(exp_rdy));
    chk("out_vld", 128'(out_vld), 128'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_src", 128'(out_src), 128'(m_q[0].src));
      chk("out_pld", 128'(out_pld), 128'(m_q[0].pld));
    end
    chk("bank_err", 128'(bank_err), 128'(m_err));
`ifdef VC_RD_ARB_PERF_CNT_EN
    for (int i = 0; i < 4; i++) chk("grant_cnt", 128'(grant_cnt[i]), 128'(m_cnt[i]));
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_rr  = 0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (m_q.size() != 0 && out_rdy) void'(m_q.pop_front());
      if (g >= 0) begin
        e.pld = in_pld[g];
        e.src = 2'(g);
        m_q.push_back(e);
        m_rr = (g + 1) % 4;
        if (in_pld[g].cmd_addr[63:62] != 2'(BANK_ID)) m_err = 1'b1;
        if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'hF, 1'b1, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and idle: requests present but nothing may be granted.
    rst_n = 1'b0;
    drive(4'hF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Round-robin with every source valid and the bank always ready.
    repeat (9) begin
      drive(4'hF, 1'b1, 1'b0);
      tick();
    end
    repeat (3) begin
      drive(4'h0, 1'b1, 1'b0);
      tick();
    end

    // Backpressure: fill the FIFO, pop once, confirm the refill waits a cycle.
    do_reset();
    repeat (4) begin
      drive(4'hF, 1'b0, 1'b0);
      tick();
    end
    drive(4'hF, 1'b1, 1'b0);
    tick();
    repeat (3) begin
      drive(4'hF, 1'b0, 1'b0);
      tick();
    end
    repeat (4) begin
      drive(4'h0, 1'b1, 1'b0);
      tick();
    end

    // Sparse requests: only E and N.
    do_reset();
    repeat (6) begin
      drive(4'b1010, 1'b1, 1'b0);
      tick();
    end

    // Bank check: one wrong-bank command, then correct ones; the flag stays set.
    do_reset();
    drive(4'b0001, 1'b1, 1'b0);
    in_pld[0].cmd_addr = 64'h4000_0000_0000_0000;
    tick();
    drive(4'h0, 1'b1, 1'b0);
    tick();
    repeat (3) begin
      drive(4'b0001, 1'b1, 1'b0);
      tick();
    end
    drive(4'h0, 1'b1, 1'b0);
    tick();

    // Random traffic with sporadic backpressure, bad addresses and resets.
    do_reset();
    repeat (400) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(4'($urandom()), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      tick();
    end
    rst_n = 1'b1;

    // Counter saturation: 20 West-only grants.
    do_reset();
    repeat (20) begin
      drive(4'b0001, 1'b1, 1'b0);
      tick();
    end
    drive(4'h0, 1'b1, 1'b0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc_rd_bank_arb.md
Name: vc_rd_bank_arb

Overview:
Per-bank read-command arbiter directly downstream of the WESN read crossbar. It merges the four per-direction streams routed to one bank (West, East, South, North) into a single command stream using round-robin arbitration. Accepted commands are buffered in a small output FIFO that decouples the crossbar from the bank pipeline. One instance is built per bank (4 total), each fed by lane BANK_ID of the crossbar's w/e/s/n_rd_* outputs.

Parameters:
BANK_ID, 0, bank index 0..3; compared against cmd_addr[63:62] of every accepted command.
DEPTH, 2, output FIFO entries; legal values 2..8.
CNT_W, 32, width of the optional grant counters.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_vld  input  4  request valid; bit 0=W, 1=E, 2=S, 3=N
in_pld  input  input_req_pld_t[3:0]  request payload, same bit order
in_rdy  output  4  request ready; at most one bit high per cycle
out_vld  output  1  bank command valid
out_pld  output  input_req_pld_t  bank command payload
out_src  output  2  source direction of out_pld (0=W, 1=E, 2=S, 3=N)
out_rdy  input  1  bank pipeline ready
bank_err  output  1  sticky: an accepted cmd_addr[63:62] != BANK_ID
grant_cnt  output  CNT_W[3:0]  per-source accepted count; present only with the optional feature

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates on the rising edge of clk.
- Reset values: out_vld=0, bank_err=0, rr_ptr=0, FIFO count=0, rd/wr pointers=0, grant_cnt=0.
- While rst_n=0, in_rdy=0 (combinationally gated).
- Reset asserted mid-operation: FIFO contents are dropped. Upstream must not assume in-flight delivery.
- Arbitration, combinational each cycle:
  - can_push = (count < DEPTH). There is no pass-through when full: a pop in the same cycle does not open a slot.
  - If can_push, grant = first set bit of in_vld, searching from rr_ptr upward modulo 4.
  - in_rdy = grant one-hot; all zero if !can_push or no in_vld.
  - in_rdy does not depend on out_rdy combinationally.
- Round-robin pointer: on a grant to source i, rr_ptr <= (i+1) mod 4. With no grant, rr_ptr holds.
- Fairness bound: with all 4 sources continuously valid and out_rdy=1, grants rotate W,E,S,N and repeat.
- FIFO:
  - Push stores {pld, src} at wr_ptr. Pop occurs when out_vld && out_rdy. Pointers wrap mod DEPTH.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
  - out_vld = (count != 0). out_pld/out_src come from the rd_ptr entry and are registered storage, not combinational from inputs.
- Latency: a command accepted in cycle N appears on out_vld in cycle N+1 at the earliest.
- Throughput: 1 command/cycle when out_rdy=1 steadily.
- Handshake:
  - out_pld/out_src hold stable while out_vld && !out_rdy.
  - Commands are never dropped or duplicated; order is preserved in grant order.
- bank_err: set on a push whose cmd_addr[63:62] != BANK_ID. The command is still forwarded. Cleared only by reset.

Optional Feature:
Macro VC_RD_ARB_PERF_CNT_EN.
- Defined: grant_cnt port exists. grant_cnt[i] increments by 1 on each grant to source i and saturates at all-ones (no wrap). Reset to 0.
- Undefined: the port and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_vld=4'hF -> in_rdy=0, out_vld=0. Release; the first grant is W (in_rdy=4'b0001).
- Round-robin, all sources valid, out_rdy=1, 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 from cycle 1. in_rdy one-hot every cycle.
- Backpressure, out_rdy=0, in_vld=4'hF, DEPTH=2 -> exactly 2 grants (W, E), then in_rdy=0. out_pld holds the W command. Raising out_rdy for 1 cycle pops W. The next grant (S) is made in the following cycle, not the pop cycle.
- Sparse requests: only E and N valid, rr_ptr=0 -> E granted, then N, then E. Sources W and S are never granted.
- Bank check, BANK_ID=2: push cmd_addr=64'h4000_0000_0000_0000 -> bank_err rises the next cycle and the command is still delivered. A later correct address leaves bank_err=1.
- Perf counters (macro defined, CNT_W=4): 20 W-only grants -> grant_cnt[0]=4'hF (saturated), others 0. With the macro undefined, the build has no grant_cnt port.
